param_stack: RTL and testbench
==============================

PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (>=2).
REQ-003 SHALL have port CLK  input  1  single clock, all state updated on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port init  input  1  synchronous clear.
REQ-006 SHALL have port push  input  1  push request.
REQ-007 SHALL have port pop  input  1  pop request.
REQ-008 SHALL have port din  input  WIDTH  data to push.
REQ-009 SHALL have port dout  output  WIDTH  registered last popped word.
REQ-010 SHALL have port top  output  WIDTH  combinational peek of top entry; 0 when empty.
REQ-011 SHALL have ports empty and full  output  1 each  occupancy flags.
REQ-012 SHALL have port count  output  clog2(DEPTH+1)  current occupancy.
REQ-013 SHALL have ports overflow and underflow  output  1 each  one-cycle error pulses.
REQ-014 SHALL have port hw_mark  output  clog2(DEPTH+1)  high-water mark (see Configuration).

Function
REQ-015 SHALL drive empty = (count==0) and full = (count==DEPTH) combinationally from count.
REQ-016 SHALL, on init=1, clear count, dout, overflow and underflow next edge, ignoring push/pop; init has highest priority.
REQ-017 SHALL, on push only and not full, write din to entry[count] and increment count; dout holds.
REQ-018 SHALL, on pop only and not empty, load dout <= entry[count-1] and decrement count; latency 1 cycle.
REQ-019 SHALL, on push and pop with count>0 (including full), load dout <= entry[count-1], overwrite entry[count-1] with din, and hold count (swap), with no error.
REQ-020 SHALL, on push and pop with count==0, load dout <= din (pass-through), and leave count at 0, with no error.
REQ-021 SHALL, on push only while full, ignore the write, hold count/dout, and pulse overflow for exactly one cycle.
REQ-022 SHALL, on pop only while empty, hold count/dout and pulse underflow for exactly one cycle.
REQ-023 SHALL deassert overflow/underflow in any cycle without a new error event; count never wraps.

Reset
REQ-024 SHALL, on RST_N=0, asynchronously set count=0, dout=0, overflow=0, underflow=0, hw_mark=0; storage array is not reset.
REQ-025 SHALL discard any in-flight operation when reset asserts mid-operation; first operation is accepted on the first rising edge after RST_N deasserts.

Configuration
REQ-026 SHALL, with macro PARAM_STACK_WATERMARK_EN defined, register hw_mark = maximum count reached since last reset or init, updated in the same edge as count.
REQ-027 SHALL, without PARAM_STACK_WATERMARK_EN, tie hw_mark to 0 and synthesise no watermark register.

Structure
REQ-028 SHALL place in shared package stack_pkg: the clog2-based count-width helper and the op encoding OP_NONE, OP_PUSH, OP_POP, OP_SWAP.
REQ-029 SHALL instantiate one sub-module stack_mem: DEPTH x WIDTH array, one synchronous write port, one asynchronous read port addressed at count-1.
REQ-030 SHALL keep all control (op decode, count, flags, errors, watermark) in param_stack.

Verification (WIDTH=8, DEPTH=4)
REQ-031 SHALL cover: push 0x11,0x22,0x33,0x44 -> full=1, count=4, top=0x44; 5th push 0x55 -> overflow pulse 1 cycle, top stays 0x44.
REQ-032 SHALL cover: after REQ-031, pop x4 -> dout 0x44,0x33,0x22,0x11 each one cycle after request, then empty=1; 5th pop -> underflow pulse, dout stays 0x11.
REQ-033 SHALL cover: stack holds 0x11,0x22; push+pop with din=0x99 -> dout=0x22, top=0x99, count=2; while full, push+pop -> swap, no overflow.
REQ-034 SHALL cover: empty, push+pop with din=0x5A -> dout=0x5A, count=0, no underflow.
REQ-035 SHALL cover: count=3, assert RST_N=0 between edges -> count=0, dout=0 immediately; separately init with push=1 -> count=0, nothing written.
REQ-036 SHALL cover: with PARAM_STACK_WATERMARK_EN, push 3, pop 2, push 1 -> hw_mark=3; after init -> 0; without macro hw_mark=0 throughout.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and helpers for the parameterised LIFO stack.
// Holds the op encoding and the occupancy-width helper.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_SWAP
  } op_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WIDTH, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_stack.sv
// LIFO stack with push/pop/swap, error pulses and optional
// high-water mark (enabled by PARAM_STACK_WATERMARK_EN).
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      init,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [WIDTH-1:0]          top,
  output logic                      empty,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  output logic [cnt_w(DEPTH)-1:0]   hw_mark
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  op_e              op;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign raddr = AW'(count_q - CW'(1));

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    op = OP_NONE;
    unique case (1'b1)
      (push & pop):  op = OP_SWAP;
      (push & ~pop): op = OP_PUSH;
      (~push & pop): op = OP_POP;
      default:       op = OP_NONE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    we      = 1'b0;
    waddr   = AW'(count_q);
    if (init) begin
      count_d = '0;
      dout_d  = '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            we      = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        OP_POP: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            dout_d  = rdata;
            count_d = count_q - CW'(1);
          end
        end
        OP_SWAP: begin
          // Empty swap passes din straight through; nothing is stored
          if (empty) begin
            dout_d = din;
          end else begin
            dout_d = rdata;
            we     = 1'b1;
            waddr  = raddr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count     = count_q;
  assign dout      = dout_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign top       = empty ? '0 : rdata;

`ifdef PARAM_STACK_WATERMARK_EN
  logic [CW-1:0] hw_q, hw_d;

  always_comb begin
    hw_d = hw_q;
    if (init) begin
      hw_d = '0;
    end else if (count_d > hw_q) begin
      hw_d = count_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hw_q <= '0;
    end else begin
      hw_q <= hw_d;
    end
  end

  assign hw_mark = hw_q;
`else
  assign hw_mark = '0;
`endif

endmodule

// File: tb/tb_param_stack.sv
// Directed self-checking bench for param_stack (WIDTH=8, DEPTH=4).
// Expected values are hand-computed per step.
module tb_param_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef PARAM_STACK_WATERMARK_EN
  localparam bit WM = 1'b1;
`else
  localparam bit WM = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             init = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] top;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic [CW-1:0]    hw_mark;

  int tests = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  param_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .init      (init),
    .push      (push),
    .pop       (pop),
    .din       (din),
    .dout      (dout),
    .top       (top),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .hw_mark   (hw_mark)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic pu, input logic po,
                     input logic [WIDTH-1:0] d);
    push = pu;
    pop  = po;
    din  = d;
    @(posedge CLK);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  function automatic logic [31:0] hw(input int v);
    return WM ? 32'(v) : 32'd0;
  endfunction

  initial begin
    #2;
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_top", top, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_hw", hw_mark, 0);
    #10 RST_N = 1'b1;

    cyc(1, 0, 8'h11);
    chk("push1_top", top, 8'h11);
    cyc(1, 0, 8'h22);
    cyc(1, 0, 8'h33);
    cyc(1, 0, 8'h44);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    chk("fill_top", top, 8'h44);
    chk("fill_dout", dout, 0);
    cyc(1, 0, 8'h55);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_top", top, 8'h44);
    chk("ovf_count", count, 4);
    cyc(0, 0, 8'h00);
    chk("ovf_clear", overflow, 0);

    cyc(0, 1, 8'h00);
    chk("pop1_dout", dout, 8'h44);
    chk("pop1_count", count, 3);
    cyc(0, 1, 8'h00);
    chk("pop2_dout", dout, 8'h33);
    cyc(0, 1, 8'h00);
    chk("pop3_dout", dout, 8'h22);
    cyc(0, 1, 8'h00);
    chk("pop4_dout", dout, 8'h11);
    chk("pop4_empty", empty, 1);
    chk("pop4_top", top, 0);
    cyc(0, 1, 8'h00);
    chk("unf_pulse", underflow, 1);
    chk("unf_dout", dout, 8'h11);
    chk("unf_count", count, 0);
    cyc(0, 0, 8'h00);
    chk("unf_clear", underflow, 0);

    cyc(1, 1, 8'h5A);
    chk("pass_dout", dout, 8'h5A);
    chk("pass_count", count, 0);
    chk("pass_unf", underflow, 0);
    chk("pass_ovf", overflow, 0);

    cyc(1, 0, 8'h11);
    cyc(1, 0, 8'h22);
    cyc(1, 1, 8'h99);
    chk("swap_dout", dout, 8'h22);
    chk("swap_top", top, 8'h99);
    chk("swap_count", count, 2);
    cyc(1, 0, 8'h33);
    cyc(1, 0, 8'h44);
    cyc(1, 1, 8'hAA);
    chk("fswap_dout", dout, 8'h44);
    chk("fswap_top", top, 8'hAA);
    chk("fswap_count", count, 4);
    chk("fswap_ovf", overflow, 0);
    chk("hw_full", hw_mark, hw(4));

    init = 1'b1;
    cyc(1, 0, 8'h77);
    init = 1'b0;
    chk("init_count", count, 0);
    chk("init_dout", dout, 0);
    chk("init_top", top, 0);
    chk("init_hw", hw_mark, 0);

    cyc(1, 0, 8'h01);
    cyc(1, 0, 8'h02);
    cyc(1, 0, 8'h03);
    cyc(0, 1, 8'h00);
    chk("wm_pop1", dout, 8'h03);
    cyc(0, 1, 8'h00);
    chk("wm_pop2", dout, 8'h02);
    chk("wm_after_pop", hw_mark, hw(3));
    cyc(1, 0, 8'h04);
    chk("wm_count", count, 2);
    chk("wm_top", top, 8'h04);
    chk("wm_hw", hw_mark, hw(3));

    cyc(1, 0, 8'h05);
    chk("pre_rst_count", count, 3);
    push = 1'b1;
    din  = 8'hEE;
    #2 RST_N = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_dout", dout, 0);
    chk("arst_hw", hw_mark, 0);
    #2 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    push = 1'b0;
    chk("post_rst_count", count, 1);
    chk("post_rst_top", top, 8'hEE);
    chk("post_rst_hw", hw_mark, hw(1));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
